// File: rtl/axi_stream_read_fifo.sv
// AXI-Stream reader: TDEST-filtered FWFT FIFO to valid/ready out, counts packets (optional AXIS_READ_DROP_EN discards misaddressed beats).
// Latency: a beat pushed on edge N is presented in the cycle after edge N; no empty bypass.
// Backpressure: o_tready low when full or TDEST mismatches (unless drop is enabled); output held until popped.
module axi_stream_read_fifo #(
    parameter int BUS_WIDTH  = 64,
    parameter int DEPTH      = 8,
    parameter int DEST_WIDTH = 8,
    parameter int ID_WIDTH   = 8
) (
    input  logic                       i_clk,
    input  logic                       i_areset,
    input  logic [DEST_WIDTH-1:0]      i_core_TID,
    input  logic                       i_tvalid,
    output logic                       o_tready,
    input  logic [BUS_WIDTH-1:0]       i_tdata,
    input  logic [BUS_WIDTH/8-1:0]     i_tkeep,
    input  logic [DEST_WIDTH-1:0]      i_tdest,
    input  logic [ID_WIDTH-1:0]        i_tid,
    input  logic                       i_tlast,
    output logic                       o_output_valid,
    input  logic                       i_output_ready,
    output logic [BUS_WIDTH-1:0]       o_transmitted_data,
    output logic [BUS_WIDTH/8-1:0]     o_tkeep,
    output logic                       o_tlast,
    output logic [ID_WIDTH-1:0]        o_tid,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic [15:0]                o_pkt_count,
    output logic [15:0]                o_drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int KW = BUS_WIDTH / 8;

    typedef struct packed {
        logic [BUS_WIDTH-1:0] data;
        logic [KW-1:0]        keep;
        logic                 last;
        logic [ID_WIDTH-1:0]  id;
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    entry_t        head;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [15:0]   pkt_cnt_q, pkt_cnt_d;
    logic          dest_match, empty, full, push, pop;

    assign dest_match = (i_tdest == i_core_TID);
    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

`ifdef AXIS_READ_DROP_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic        drop;

    // Misaddressed beats are always acknowledged so they cannot stall the shared switch.
    assign o_tready = ~i_areset & (dest_match ? ~full : 1'b1);
    assign drop     = i_tvalid & ~dest_match & ~i_areset;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && drop_cnt_q != 16'hFFFF)
            drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) drop_cnt_q <= '0;
        else          drop_cnt_q <= drop_cnt_d;
    end

    assign o_drop_count = drop_cnt_q;
`else
    assign o_tready     = ~i_areset & dest_match & ~full;
    assign o_drop_count = '0;
`endif

    assign push = i_tvalid & o_tready & dest_match;
    assign pop  = ~empty & i_output_ready;
    assign head = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        pkt_cnt_d = pkt_cnt_q;
        for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = '{data: i_tdata, keep: i_tkeep, last: i_tlast, id: i_tid};
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            if (head.last) pkt_cnt_d = pkt_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            pkt_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end

    // Head fields are masked so an empty (or resetting) FIFO presents zeros.
    assign o_output_valid     = ~empty;
    assign o_transmitted_data = head.data & {BUS_WIDTH{~empty}};
    assign o_tkeep            = head.keep & {KW{~empty}};
    assign o_tlast            = head.last & ~empty;
    assign o_tid              = head.id & {ID_WIDTH{~empty}};
    assign o_count            = wr_ptr_q - rd_ptr_q;
    assign o_pkt_count        = pkt_cnt_q;
endmodule

// File: tb/tb_axi_stream_read_fifo.sv
// Directed bench for axi_stream_read_fifo with a queue-based reference model checked every cycle.
module tb_axi_stream_read_fifo;
`ifdef AXIS_READ_DROP_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif
    localparam int DEPTH = 8;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        logic [7:0]  id;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  core_tid;
    logic        tvalid, tready, tlast, ovalid, oready, olast;
    logic [63:0] tdata, odata;
    logic [7:0]  tkeep, okeep, tdest, tid, oid;
    logic [3:0]  ocount;
    logic [15:0] pkt_count, drop_count;

    beat_t       model[$];
    logic [15:0] m_pkt  = 16'd0;
    logic [15:0] m_drop = 16'd0;
    int          checks = 0;
    int          failures = 0;

    axi_stream_read_fifo #(.BUS_WIDTH(64), .DEPTH(DEPTH), .DEST_WIDTH(8), .ID_WIDTH(8)) dut (
        .i_clk(clk), .i_areset(rst), .i_core_TID(core_tid),
        .i_tvalid(tvalid), .o_tready(tready), .i_tdata(tdata), .i_tkeep(tkeep),
        .i_tdest(tdest), .i_tid(tid), .i_tlast(tlast),
        .o_output_valid(ovalid), .i_output_ready(oready),
        .o_transmitted_data(odata), .o_tkeep(okeep), .o_tlast(olast), .o_tid(oid),
        .o_count(ocount), .o_pkt_count(pkt_count), .o_drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, compare mid-cycle, update model at the rising edge.
    task automatic step(input logic v, input logic [63:0] d, input logic [7:0] k, input logic l,
                        input logic [7:0] dst, input logic [7:0] id, input logic ordy);
        logic exp_rdy, push_e, drop_e, pop_e;
        tvalid = v; tdata = d; tkeep = k; tlast = l; tdest = dst; tid = id; oready = ordy;
        #1;
        exp_rdy = (dst == core_tid) ? (model.size() < DEPTH) : DROP_EN;
        chk("tready", 64'(tready), 64'(exp_rdy));
        chk("valid", 64'(ovalid), 64'(model.size() > 0));
        chk("count", 64'(ocount), 64'(model.size()));
        chk("pkt_count", 64'(pkt_count), 64'(m_pkt));
        chk("drop_count", 64'(drop_count), 64'(m_drop));
        if (model.size() > 0) begin
            chk("head_data", odata, model[0].d);
            chk("head_keep", 64'(okeep), 64'(model[0].k));
            chk("head_last", 64'(olast), 64'(model[0].l));
            chk("head_tid", 64'(oid), 64'(model[0].id));
        end
        push_e = v && exp_rdy && (dst == core_tid);
        drop_e = v && (dst != core_tid) && DROP_EN;
        pop_e  = (model.size() > 0) && ordy;
        @(posedge clk);
        if (pop_e) begin
            if (model[0].l) m_pkt = m_pkt + 16'd1;
            void'(model.pop_front());
        end
        if (push_e) model.push_back('{d: d, k: k, l: l, id: id});
        if (drop_e && m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic ordy);
        repeat (n) step(1'b0, 64'd0, 8'h00, 1'b0, 8'd3, 8'h00, ordy);
    endtask

    initial begin
        rst = 1'b1; core_tid = 8'd3; oready = 1'b0;
        tvalid = 1'b0; tdata = '0; tkeep = '0; tlast = 1'b0; tdest = 8'd3; tid = '0;
        #2;
        chk("rst_valid", 64'(ovalid), 64'd0);
        chk("rst_tready", 64'(tready), 64'd0);
        chk("rst_count", 64'(ocount), 64'd0);
        chk("rst_pkt", 64'(pkt_count), 64'd0);
        #2 rst = 1'b0;
        @(negedge clk);

        // In-order delivery with one cycle of latency
        for (int i = 1; i <= 4; i++)
            step(1'b1, 64'(i * 'h11), 8'hFF, i == 4, 8'd3, 8'h01, 1'b1);
        idle(2, 1'b1);
        chk("t1_pkt_count", 64'(pkt_count), 64'd1);

        // Fill to full, one pop, then refill on the following cycle
        for (int i = 0; i < 10; i++)
            step(1'b1, 64'h100 + 64'(i), 8'hFF, 1'b0, 8'd3, 8'h02, 1'b0);
        chk("t2_full_count", 64'(ocount), 64'd8);
        step(1'b1, 64'h200, 8'hFF, 1'b0, 8'd3, 8'h02, 1'b1);
        step(1'b1, 64'h201, 8'hFF, 1'b1, 8'd3, 8'h02, 1'b0);
        idle(9, 1'b1);

        // Steady push/pop at occupancy 3 across pointer wrap
        for (int i = 0; i < 3; i++)
            step(1'b1, 64'h300 + 64'(i), 8'hFF, 1'b0, 8'd3, 8'h03, 1'b0);
        for (int i = 0; i < 20; i++)
            step(1'b1, 64'h400 + 64'(i), 8'hFF, i[2], 8'd3, 8'h04, 1'b1);
        chk("t3_count", 64'(ocount), 64'd3);
        idle(4, 1'b1);

        // Misaddressed beat
        for (int i = 0; i < 3; i++)
            step(1'b1, 64'h500, 8'hFF, 1'b1, 8'd5, 8'h05, 1'b1);
        idle(1, 1'b1);

        // Asynchronous reset between edges with 5 entries stored
        for (int i = 0; i < 5; i++)
            step(1'b1, 64'h600 + 64'(i), 8'hFF, i == 2, 8'd3, 8'h06, 1'b0);
        tvalid = 1'b0; oready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 64'(ovalid), 64'd0);
        chk("arst_count", 64'(ocount), 64'd0);
        chk("arst_pkt", 64'(pkt_count), 64'd0);
        chk("arst_data", odata, 64'd0);
        chk("arst_tready", 64'(tready), 64'd0);
        model.delete(); m_pkt = 16'd0; m_drop = 16'd0;
        #1 rst = 1'b0;
        @(negedge clk);
        step(1'b1, 64'hAA, 8'hFF, 1'b0, 8'd3, 8'h0A, 1'b0);
        chk("t5_first_data", odata, 64'hAA);
        idle(2, 1'b1);

        // Packet counter wrap; keep/tid carried intact
        for (int i = 0; i < 65536; i++) begin
            if (i == 0) step(1'b1, 64'h7000, 8'h0F, 1'b1, 8'd3, 8'h7E, 1'b1);
            else        step(1'b1, 64'(i), 8'hFF, 1'b1, 8'd3, 8'(i), 1'b1);
        end
        idle(3, 1'b1);
        chk("t6_pkt_wrap", 64'(pkt_count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axi_stream_read_fifo.md
Name: axi_stream_read_fifo

Overview:
- Parametrised successor to the single-transfer AXI-Stream reader.
- Accepts AXI-Stream beats addressed to this core (TDEST == i_core_TID) into a DEPTH-entry first-word-fall-through FIFO, sustaining one beat per clock on both sides.
- Forwards TDATA/TKEEP/TLAST/TID to a valid/ready output interface.
- Sits between the network-side stream switch and the FINN core input adapter; counts completed packets.

Parameters:
BUS_WIDTH, 64, TDATA width in bits; multiple of 8
DEPTH, 8, FIFO entries; power of 2, >= 2
DEST_WIDTH, 8, TDEST / core-ID width
ID_WIDTH, 8, TID width

Ports:
i_clk  in  1  clock, all logic on rising edge
i_areset  in  1  reset, asynchronous, active-high
i_core_TID  in  DEST_WIDTH  destination ID this instance accepts; quasi-static
i_tvalid  in  1  AXI-S valid
o_tready  out  1  AXI-S ready
i_tdata  in  BUS_WIDTH  AXI-S data
i_tkeep  in  BUS_WIDTH/8  AXI-S byte keep
i_tdest  in  DEST_WIDTH  AXI-S destination
i_tid  in  ID_WIDTH  AXI-S stream ID
i_tlast  in  1  AXI-S last beat of packet
o_output_valid  out  1  head entry valid
i_output_ready  in  1  consumer ready
o_transmitted_data  out  BUS_WIDTH  head data
o_tkeep  out  BUS_WIDTH/8  head keep
o_tlast  out  1  head last
o_tid  out  ID_WIDTH  head ID
o_count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
o_pkt_count  out  16  packets (TLAST beats) delivered on output
o_drop_count  out  16  beats discarded for TDEST mismatch (see Optional Feature)

Behaviour:
- Reset (i_areset high, takes effect immediately, no clock needed):
  - Pointers, o_count, o_pkt_count, o_drop_count cleared to 0.
  - o_output_valid=0, o_tready=0; head outputs (data/keep/last/tid) read 0.
  - Reset mid-packet discards all stored beats; no partial-packet recovery.
- Match: dest_match = (i_tdest == i_core_TID), combinational.
- o_tready = ~full & dest_match & ~reset; may depend combinationally on i_tdest.
- Push: occurs on a rising edge where i_tvalid & o_tready. Writes {tdata,tkeep,tlast,tid} at wr_ptr; wr_ptr increments.
- Pop: occurs on a rising edge where o_output_valid & i_output_ready; rd_ptr increments.
- Pointers are $clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
  - empty = (wr_ptr == rd_ptr).
  - full = MSBs differ and lower bits are equal.
- o_output_valid = ~empty. Head outputs are driven from storage[rd_ptr]; values are don't-care when empty but must be stable while valid and not popped.
- Latency: a beat pushed at edge N is visible (o_output_valid=1) in the cycle after edge N; no bypass when empty.
- Simultaneous push and pop:
  - Not full: o_count is unchanged.
  - Full: o_tready=0, so pop only. o_tready rises in the following cycle (no same-cycle full bypass).
- o_count = wr_ptr - rd_ptr; +1 on push only, -1 on pop only.
- o_pkt_count increments on each pop with head o_tlast=1; wraps 65535 -> 0.
- Ordering is strictly FIFO; TID is carried but never used for routing.
- i_tvalid must not depend on o_tready (AXI rule). The block never drops an accepted beat.

Optional Feature:
- Macro: AXIS_READ_DROP_EN
- Defined:
  - Mismatched beats (i_tvalid & ~dest_match) are acknowledged: o_tready=1 regardless of full. They are discarded, not written.
  - o_drop_count increments per discarded beat, saturating at 65535.
  - Prevents a misaddressed stream from stalling the shared bus.
- Undefined:
  - Mismatched beats see o_tready=0 and stall.
  - o_drop_count is tied to 0.

Test Plan:
1. i_core_TID=3; 4 beats tdest=3 (data 0x11..0x44, last on 4th), i_output_ready=1 -> output 0x11,0x22,0x33,0x44 in order, one per cycle after a 1-cycle latency; o_pkt_count=1.
2. DEPTH=8, i_output_ready=0, 10 beats offered -> o_tready drops after the 8th push; o_count=8. Raise ready for one cycle -> o_count=7, then o_tready=1 next cycle; 9th beat accepted.
3. Continuous push and pop at occupancy 3 for 20 cycles -> o_count holds at 3; data order intact across pointer wrap (more than 2*DEPTH pushes).
4. tdest=5 beat with i_core_TID=3 -> without macro: o_tready=0 indefinitely, o_count=0. With AXIS_READ_DROP_EN: accepted in 1 cycle, o_drop_count=1, o_output_valid stays 0.
5. i_areset pulsed asynchronously between clock edges with 5 entries stored -> o_output_valid, o_count, o_pkt_count read 0 before the next edge. After release, the next pushed beat 0xAA is the first output.
6. Drive 65536 single-beat packets -> o_pkt_count wraps to 0; TKEEP=0x0F and TID=0x7E on a beat appear unchanged on o_tkeep/o_tid.
